alu_seq: RTL and testbench

//  Parametrised, registered ALU for the multicycle datapath. Replaces the purely

---
 rtl/alu_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and NZCV flags.
// Define ALU_SEQ_MUL_EN to make op 101 an iterative shift-add multiplier; otherwise it is reserved.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow.
    always_comb begin
        b_op    = op[0] ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, op[0]};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_ORR:  alu_res = a | b;
            OP_EOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcnd_q, mcnd_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcnd_d   = mcnd_q;
        mplr_d   = mplr_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        acc_step = acc_q + (mplr_q[0] ? mcnd_q : '0);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        mcnd_d  = a;
                        mplr_d  = b;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle; the last step publishes the low half.
                acc_d  = acc_step;
                mcnd_d = mcnd_q << 1;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    result_d = acc_step;
                    flags_d  = {acc_step[WIDTH-1], (acc_step == '0), 2'b00};
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcnd_q   <= '0;
            mplr_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcnd_q   <= mcnd_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == S_MUL);
`else
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        if (start) begin
            result_d = alu_res;
            flags_d  = alu_flags;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy = 1'b0;
`endif

    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit and an 8-bit instance share one clock and reset.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32, result32;
    logic [7:0]  a8, b8, result8;
    logic        busy32, done32, busy8, done8;
    logic [3:0]  flags32, flags8;

    int tests_run = 0;
    int tests_failed = 0;

    logic [35:0] exp32[$];
    logic [35:0] exp8[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .flags(flags32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .flags(flags8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model written from signed/unsigned arithmetic, returns {N,Z,C,V,result}.
    function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
        logic [63:0] msk, ua, ub, full, r;
        logic        n, z, c, v, sa, sb, sr;
        msk = (64'd1 << w) - 64'd1;
        ua = {32'b0, x} & msk;
        ub = {32'b0, y} & msk;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin full = ua + ub; r = full & msk; c = full[w]; end
            3'd1: begin r = (ua - ub) & msk; c = (ua >= ub); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: if (MUL_EN) r = (ua * ub) & msk;
            default: r = '0;
        endcase
        sa = ua[w-1];
        sb = ub[w-1];
        sr = r[w-1];
        if (o == 3'd0) v = (sa == sb) && (sr != sa);
        if (o == 3'd1) v = (sa != sb) && (sr != sa);
        n = sr;
        z = (r == 64'd0);
        return {n, z, c, v, r[31:0]};
    endfunction

    always @(negedge clk) begin
        logic [35:0] e;
        if (done32) begin
            if (exp32.size() == 0) checkOutput("done32_spurious", 64'd1, 64'd0);
            else begin
                e = exp32.pop_front();
                checkOutput("result32", {32'b0, result32}, {32'b0, e[31:0]});
                checkOutput("flags32", {60'b0, flags32}, {60'b0, e[35:32]});
            end
        end
        if (done8) begin
            if (exp8.size() == 0) checkOutput("done8_spurious", 64'd1, 64'd0);
            else begin
                e = exp8.pop_front();
                checkOutput("result8", {56'b0, result8}, {56'b0, e[7:0]});
                checkOutput("flags8", {60'b0, flags8}, {60'b0, e[35:32]});
            end
        end
    end

    // Issue one op on the 32-bit ALU and track busy/done each cycle until its completion.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input bit spam);
        int          lat;
        bit          is_mul;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        is_mul = MUL_EN && (o == 3'd5);
        lat = is_mul ? 33 : 1;
        @(negedge clk);
        held_r = result32;
        held_f = flags32;
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        exp32.push_back(model(o, x, y, 32));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checkOutput("busy32", {63'b0, busy32}, {63'b0, (is_mul && k < lat)});
            checkOutput("done32", {63'b0, done32}, {63'b0, (k == lat)});
            if (k < lat) begin
                checkOutput("hold_result32", {32'b0, result32}, {32'b0, held_r});
                checkOutput("hold_flags32", {60'b0, flags32}, {60'b0, held_f});
            end
            if (spam && k < lat) begin
                start32 = 1'b1; op32 = 3'd0; a32 = $urandom; b32 = $urandom;
            end else start32 = 1'b0;
        end
        start32 = 1'b0;
    endtask

    task automatic applyStimulus8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int lat;
        lat = (MUL_EN && o == 3'd5) ? 9 : 1;
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        exp8.push_back(model(o, {24'b0, x}, {24'b0, y}, 8));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            checkOutput("done8", {63'b0, done8}, {63'b0, (k == lat)});
        end
    endtask

    initial begin
        reset = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {63'b0, busy32}, 64'd0);
        checkOutput("reset_done", {63'b0, done32}, 64'd0);
        checkOutput("reset_result", {32'b0, result32}, 64'd0);
        checkOutput("reset_flags", {60'b0, flags32}, 64'd0);
        reset = 1'b0;

        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("add_carry_flags", {60'b0, flags32}, 64'h6);
        applyStimulus(3'd1, 32'd5, 32'd7, 1'b0);
        checkOutput("sub_borrow_result", {32'b0, result32}, 64'hFFFF_FFFE);
        applyStimulus(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        checkOutput("add_ovf_flags", {60'b0, flags32}, 64'h9);
        applyStimulus(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        applyStimulus(3'd3, 32'h8000_0000, 32'h0000_0001, 1'b0);
        applyStimulus(3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        applyStimulus(3'd6, 32'h1234_5678, 32'h1, 1'b0);
        applyStimulus(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'd5, 32'h0001_0000, 32'h0001_0000, 1'b0);
        applyStimulus(3'd5, 32'd7, 32'd6, 1'b0);
        applyStimulus(3'd5, 32'hDEAD_BEEF, 32'h1234_5679, 1'b1);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start32 = 1'b1;
            op32 = 3'($urandom_range(0, 4));
            a32 = $urandom;
            b32 = $urandom;
            exp32.push_back(model(op32, a32, b32, 32));
        end
        @(negedge clk);
        start32 = 1'b0;
        repeat (2) @(negedge clk);

        // Abort an op with reset ten cycles in; nothing from it may complete afterwards.
        @(negedge clk);
        start32 = 1'b1; op32 = 3'd5; a32 = 32'd3; b32 = 32'd9;
        exp32.push_back(model(3'd5, 32'd3, 32'd9, 32));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {63'b0, busy32}, 64'd0);
        checkOutput("abort_done", {63'b0, done32}, 64'd0);
        checkOutput("abort_result", {32'b0, result32}, 64'd0);
        checkOutput("abort_flags", {60'b0, flags32}, 64'd0);
        reset = 1'b0;
        exp32.delete();
        repeat (40) begin
            @(negedge clk);
            checkOutput("abort_no_done", {63'b0, done32}, 64'd0);
        end
        applyStimulus(3'd0, 32'd2, 32'd3, 1'b0);
        checkOutput("post_abort_add", {32'b0, result32}, 64'd5);

        applyStimulus8(3'd5, 8'h03, 8'h04);
        applyStimulus8(3'd0, 8'h80, 8'h80);
        checkOutput("w8_add_flags", {60'b0, flags8}, 64'h7);
        applyStimulus8(3'd1, 8'h10, 8'h20);
        applyStimulus8(3'd0, 8'h7F, 8'h01);
        applyStimulus8(3'd3, 8'h00, 8'h00);
        checkOutput("w8_busy", {63'b0, busy8}, 64'd0);

        repeat (3) @(negedge clk);
        checkOutput("pending32", 64'(exp32.size()), 64'd0);
        checkOutput("pending8", 64'(exp8.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
